cnt_pwm_gen: RTL and testbench

- Downstream consumer of the free-running 4-bit counter output `cnt`; turns it into a PWM waveform with a software-loadable duty cycle.
- Duty updates arrive over a valid/ready handshake into a shadow register and take effect only at counter wrap (glitch-free).
- Also checks that the incoming count really increments by 1 each cycle, flags violations, and reports wraps and periods.
- Sits between the counter and the output pin/LED driver.

---
 rtl/cnt_pwm_pkg.sv | 11 +
 rtl/cnt_seq_check.sv | 29 ++
 rtl/cnt_pwm_gen.sv | 97 +++++++++
 tb/tb_cnt_pwm_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pwm_pkg.sv
// Shared constants, state encoding and helpers for the counter-driven PWM generator.
package cnt_pwm_pkg;
   localparam int CNT_W_DEF = 4;
   localparam int PER_W_DEF = 8;

   typedef enum logic [0:0] {SYNC = 1'b0, RUN = 1'b1} state_e;

   function automatic int unsigned cnt_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction
endpackage

// File: rtl/cnt_seq_check.sv
// Tracks an incoming free-running count; flags wraps (MAX->0) and any step other than +1.
import cnt_pwm_pkg::*;

module cnt_seq_check #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             res,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             wrap_evt,
   output logic             seq_err
);
   localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

   logic [CNT_W-1:0] cnt_p1;
   logic             prev_vld_p1;
   logic [CNT_W-1:0] cnt_inc;

   // stage p1: previous count, valid once one post-reset sample has been taken
   always_ff @(posedge clk) begin
      cnt_p1 <= cnt_i;
      if (res) prev_vld_p1 <= 1'b0;
      else     prev_vld_p1 <= 1'b1;
   end

   assign cnt_inc  = cnt_p1 + CNT_W'(1);
   assign wrap_evt = prev_vld_p1 && (cnt_p1 == MAX) && (cnt_i == '0);
   assign seq_err  = prev_vld_p1 && (cnt_i != cnt_inc);
endmodule

// File: rtl/cnt_pwm_gen.sv
// PWM generator driven by an upstream counter; duty reloads only at counter wrap.
import cnt_pwm_pkg::*;

module cnt_pwm_gen #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PER_W = PER_W_DEF
) (
   input  logic             clk,
   input  logic             res,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [CNT_W-1:0] duty_i,
   input  logic             duty_valid_i,
   output logic             duty_ready_o,
   output logic             pwm_o,
   output logic             wrap_o,
   output logic [CNT_W-1:0] duty_active_o,
   output logic [PER_W-1:0] period_cnt_o,
   output logic             cnt_err_o
);
   localparam logic [0:0]       ST_SYNC = SYNC;
   localparam logic [0:0]       ST_RUN  = RUN;
   localparam logic [PER_W-1:0] PER_MAX = PER_W'(cnt_max(PER_W));

   logic             wrap_evt;
   logic             seq_err;
   logic             wrap_ok;
   logic             accept;
   logic             pwm_en;
   logic [CNT_W-1:0] duty_eff;

   logic [0:0]       state_p1;
   logic [CNT_W-1:0] shadow_p1;
   logic             shadow_full_p1;
   logic             pwm_p1;
   logic             wrap_p1;
   logic [CNT_W-1:0] duty_act_p1;
   logic [PER_W-1:0] period_p1;
   logic             err_p1;

   cnt_seq_check #(.CNT_W(CNT_W)) u_seq (
      .clk      (clk),
      .res      (res),
      .cnt_i    (cnt_i),
      .wrap_evt (wrap_evt),
      .seq_err  (seq_err)
   );

   assign wrap_ok      = wrap_evt && !seq_err;
   assign duty_ready_o = !shadow_full_p1 && !res;
   assign accept       = duty_valid_i && duty_ready_o;
   assign pwm_en       = (state_p1 == ST_RUN) || wrap_ok;

   // A duty arriving on the wrap cycle itself bypasses the empty shadow.
   always_comb begin
      duty_eff = duty_act_p1;
      if (wrap_ok) begin
         if (shadow_full_p1) duty_eff = shadow_p1;
         else if (accept)    duty_eff = duty_i;
      end
   end

   // stage p1: control state and registered outputs
   always_ff @(posedge clk) begin
      if (res) begin
         state_p1       <= ST_SYNC;
         shadow_full_p1 <= 1'b0;
         pwm_p1         <= 1'b0;
         wrap_p1        <= 1'b0;
         duty_act_p1    <= '0;
         period_p1      <= '0;
         err_p1         <= 1'b0;
      end else begin
         wrap_p1     <= wrap_ok;
         pwm_p1      <= pwm_en && (cnt_i < duty_eff);
         duty_act_p1 <= duty_eff;
         if (seq_err) begin
            err_p1   <= 1'b1;
            state_p1 <= ST_SYNC;
         end else if (wrap_ok) begin
            state_p1 <= ST_RUN;
         end
         if (wrap_ok && (period_p1 != PER_MAX)) period_p1 <= period_p1 + PER_W'(1);
         if (accept && !wrap_ok) shadow_full_p1 <= 1'b1;
         else if (wrap_ok)       shadow_full_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) shadow_p1 <= duty_i;
   end

   assign pwm_o         = pwm_p1;
   assign wrap_o        = wrap_p1;
   assign duty_active_o = duty_act_p1;
   assign period_cnt_o  = period_p1;
   assign cnt_err_o     = err_p1;
endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Directed bench for cnt_pwm_gen: wrap tracking, duty reload, bypass, sequence errors, saturation, reset.
module tb_cnt_pwm_gen;
   logic       clk = 1'b0;
   logic       res;
   logic [3:0] cnt_i;
   logic [3:0] duty_i;
   logic       duty_valid_i;
   logic       duty_ready_o;
   logic       pwm_o;
   logic       wrap_o;
   logic [3:0] duty_active_o;
   logic [7:0] period_cnt_o;
   logic       cnt_err_o;

   int vecs = 0;
   int errs = 0;

   cnt_pwm_gen dut (
      .clk           (clk),
      .res           (res),
      .cnt_i         (cnt_i),
      .duty_i        (duty_i),
      .duty_valid_i  (duty_valid_i),
      .duty_ready_o  (duty_ready_o),
      .pwm_o         (pwm_o),
      .wrap_o        (wrap_o),
      .duty_active_o (duty_active_o),
      .period_cnt_o  (period_cnt_o),
      .cnt_err_o     (cnt_err_o)
   );

   always #5 clk = ~clk;

   task automatic apply(input logic [3:0] v, input logic vld, input logic [3:0] d);
      cnt_i = v;
      duty_valid_i = vld;
      duty_i = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      res = 1'b1;
      apply(4'd0, 1'b0, 4'd0);
      apply(4'd0, 1'b0, 4'd0);
      vecs++;
      if ({pwm_o, wrap_o, duty_active_o, period_cnt_o, cnt_err_o} !== 15'd0) begin
         errs++;
         $display("FAIL reset_outs got %b want 0", {pwm_o, wrap_o, duty_active_o, period_cnt_o, cnt_err_o});
      end
      vecs++;
      if (duty_ready_o !== 1'b0) begin
         errs++;
         $display("FAIL reset_ready got %b want 0", duty_ready_o);
      end
      res = 1'b0;
      #1;
      vecs++;
      if (duty_ready_o !== 1'b1) begin
         errs++;
         $display("FAIL ready_after_reset got %b want 1", duty_ready_o);
      end
   endtask

   task automatic test_free_run();
      for (int v = 0; v < 16; v++) begin
         apply(4'(v), 1'b0, 4'd0);
         vecs++;
         if ({wrap_o, pwm_o} !== 2'b00) begin
            errs++;
            $display("FAIL sync_idle v=%0d got wrap/pwm %b want 00", v, {wrap_o, pwm_o});
         end
      end
      for (int p = 1; p <= 3; p++) begin
         apply(4'd0, 1'b0, 4'd0);
         vecs++;
         if ({wrap_o, pwm_o, period_cnt_o} !== {1'b1, 1'b0, 8'(p)}) begin
            errs++;
            $display("FAIL wrap_period p=%0d got wrap=%b pwm=%b per=%0d want 1 0 %0d", p, wrap_o, pwm_o, period_cnt_o, p);
         end
         for (int v = 1; v < 16; v++) begin
            apply(4'(v), 1'b0, 4'd0);
            vecs++;
            if ({wrap_o, pwm_o} !== 2'b00) begin
               errs++;
               $display("FAIL run_duty0 p=%0d v=%0d got %b want 00", p, v, {wrap_o, pwm_o});
            end
         end
      end
      vecs++;
      if (cnt_err_o !== 1'b0) begin
         errs++;
         $display("FAIL no_err got %b want 0", cnt_err_o);
      end
   endtask

   task automatic test_load_duty();
      for (int v = 0; v < 8; v++) apply(4'(v), 1'b0, 4'd0);
      apply(4'd8, 1'b1, 4'd5);
      vecs++;
      if ({duty_ready_o, duty_active_o} !== {1'b0, 4'd0}) begin
         errs++;
         $display("FAIL load_hold got ready=%b act=%0d want 0 0", duty_ready_o, duty_active_o);
      end
      for (int v = 9; v < 16; v++) apply(4'(v), 1'b0, 4'd0);
      vecs++;
      if ({duty_active_o, pwm_o} !== {4'd0, 1'b0}) begin
         errs++;
         $display("FAIL pre_wrap got act=%0d pwm=%b want 0 0", duty_active_o, pwm_o);
      end
      for (int v = 0; v < 16; v++) begin
         apply(4'(v), 1'b0, 4'd0);
         if (v == 0) begin
            vecs++;
            if ({duty_active_o, duty_ready_o} !== {4'd5, 1'b1}) begin
               errs++;
               $display("FAIL duty5_take got act=%0d ready=%b want 5 1", duty_active_o, duty_ready_o);
            end
         end
         vecs++;
         if (pwm_o !== (v < 5)) begin
            errs++;
            $display("FAIL pwm_duty5 v=%0d got %b want %b", v, pwm_o, (v < 5));
         end
      end
   endtask

   task automatic test_bypass();
      apply(4'd0, 1'b1, 4'd12);
      vecs++;
      if ({duty_active_o, pwm_o, duty_ready_o, wrap_o} !== {4'd12, 1'b1, 1'b1, 1'b1}) begin
         errs++;
         $display("FAIL bypass got act=%0d pwm=%b ready=%b wrap=%b want 12 1 1 1", duty_active_o, pwm_o, duty_ready_o, wrap_o);
      end
      for (int v = 1; v < 16; v++) begin
         apply(4'(v), 1'b0, 4'd0);
         vecs++;
         if (pwm_o !== (v < 12)) begin
            errs++;
            $display("FAIL pwm_duty12 v=%0d got %b want %b", v, pwm_o, (v < 12));
         end
      end
   endtask

   task automatic test_skip();
      for (int v = 0; v < 7; v++) apply(4'(v), 1'b0, 4'd0);
      apply(4'd9, 1'b0, 4'd0);
      vecs++;
      if ({cnt_err_o, wrap_o} !== 2'b10) begin
         errs++;
         $display("FAIL skip_err got err/wrap %b want 10", {cnt_err_o, wrap_o});
      end
      for (int v = 10; v < 16; v++) begin
         apply(4'(v), 1'b0, 4'd0);
         vecs++;
         if ({pwm_o, cnt_err_o, wrap_o} !== 3'b010) begin
            errs++;
            $display("FAIL resync v=%0d got pwm/err/wrap %b want 010", v, {pwm_o, cnt_err_o, wrap_o});
         end
      end
      apply(4'd0, 1'b0, 4'd0);
      vecs++;
      if ({wrap_o, pwm_o, cnt_err_o} !== 3'b111) begin
         errs++;
         $display("FAIL rerun got wrap/pwm/err %b want 111", {wrap_o, pwm_o, cnt_err_o});
      end
      for (int v = 1; v < 16; v++) begin
         apply(4'(v), 1'b0, 4'd0);
         vecs++;
         if (pwm_o !== (v < 12)) begin
            errs++;
            $display("FAIL pwm_after_rerun v=%0d got %b want %b", v, pwm_o, (v < 12));
         end
      end
   endtask

   task automatic test_duty_extremes();
      for (int v = 0; v < 16; v++) apply(4'(v), (v == 3), 4'd15);
      for (int v = 0; v < 16; v++) begin
         apply(4'(v), (v == 5), 4'd0);
         if (v == 0) begin
            vecs++;
            if (duty_active_o !== 4'd15) begin
               errs++;
               $display("FAIL duty15_take got %0d want 15", duty_active_o);
            end
         end
         vecs++;
         if (pwm_o !== (v < 15)) begin
            errs++;
            $display("FAIL pwm_duty15 v=%0d got %b want %b", v, pwm_o, (v < 15));
         end
      end
      for (int v = 0; v < 16; v++) begin
         apply(4'(v), 1'b0, 4'd0);
         vecs++;
         if ({duty_active_o, pwm_o} !== {4'd0, 1'b0}) begin
            errs++;
            $display("FAIL duty0 v=%0d got act=%0d pwm=%b want 0 0", v, duty_active_o, pwm_o);
         end
      end
   endtask

   task automatic test_saturation();
      for (int p = 0; p < 260; p++)
         for (int v = 0; v < 16; v++) apply(4'(v), 1'b0, 4'd0);
      vecs++;
      if (period_cnt_o !== 8'd255) begin
         errs++;
         $display("FAIL period_sat got %0d want 255", period_cnt_o);
      end
      apply(4'd0, 1'b0, 4'd0);
      vecs++;
      if ({wrap_o, period_cnt_o} !== {1'b1, 8'd255}) begin
         errs++;
         $display("FAIL period_hold got wrap=%b per=%0d want 1 255", wrap_o, period_cnt_o);
      end
      for (int v = 1; v < 16; v++) apply(4'(v), 1'b0, 4'd0);
   endtask

   task automatic test_reset_mid();
      for (int v = 0; v < 4; v++) apply(4'(v), 1'b0, 4'd0);
      apply(4'd4, 1'b1, 4'd7);
      vecs++;
      if (duty_ready_o !== 1'b0) begin
         errs++;
         $display("FAIL shadow_pending got ready=%b want 0", duty_ready_o);
      end
      for (int v = 5; v < 10; v++) apply(4'(v), 1'b0, 4'd0);
      res = 1'b1;
      apply(4'd10, 1'b0, 4'd0);
      vecs++;
      if ({pwm_o, wrap_o, duty_active_o, period_cnt_o, cnt_err_o, duty_ready_o} !== 16'd0) begin
         errs++;
         $display("FAIL midreset got %b want 0", {pwm_o, wrap_o, duty_active_o, period_cnt_o, cnt_err_o, duty_ready_o});
      end
      res = 1'b0;
      #1;
      vecs++;
      if (duty_ready_o !== 1'b1) begin
         errs++;
         $display("FAIL shadow_discard_ready got %b want 1", duty_ready_o);
      end
      for (int v = 11; v < 16; v++) apply(4'(v), 1'b0, 4'd0);
      apply(4'd0, 1'b0, 4'd0);
      vecs++;
      if ({wrap_o, duty_active_o, period_cnt_o, pwm_o} !== {1'b1, 4'd0, 8'd1, 1'b0}) begin
         errs++;
         $display("FAIL post_reset_wrap got wrap=%b act=%0d per=%0d pwm=%b want 1 0 1 0", wrap_o, duty_active_o, period_cnt_o, pwm_o);
      end
   endtask

   initial begin
      res = 1'b1;
      cnt_i = 4'd0;
      duty_i = 4'd0;
      duty_valid_i = 1'b0;
      test_reset();
      test_free_run();
      test_load_duty();
      test_bypass();
      test_skip();
      test_duty_extremes();
      test_saturation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
